cmd_registry: RTL and testbench

Real-time command registry: a FIFO of burst commands written by the host-side control logic and delivered one at a time to the burst sequencer through its `WR_DATA` / `MEM_*` load port. The registry answers the sequencer's `REQ_COMMAND` level handshake. It issues the next command only after the current one has completed. Commands whose start time is already too close or already past are discarded and counted. Runs in the 48 MHz system clock domain alongside the sequencer.

---
 rtl/cmd_registry.sv | 223 ++++++++++++++++++++++
 tb/tb_cmd_registry.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_registry.sv
// Command registry: FIFO of burst commands handed one at a time to the burst sequencer.
// Late commands are discarded; REQ_COMMAND edges pace delivery of the next command.
module cmd_registry #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned MARGIN = 48
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic [63:0]            TIME,
    input  logic                   HOST_WR,
    input  logic [47:0]            H_DDS_freq,
    input  logic [47:0]            H_DDS_delta_freq,
    input  logic [31:0]            H_DDS_delta_rate,
    input  logic [63:0]            H_TIME_START,
    input  logic [15:0]            H_N_impuls,
    input  logic [1:0]             H_TYPE_impulse,
    input  logic [31:0]            H_Interval_Ti,
    input  logic [31:0]            H_Interval_Tp,
    input  logic [31:0]            H_Tblank1,
    input  logic [31:0]            H_Tblank2,
    input  logic                   CLEAR,
    output logic                   FULL,
    output logic                   EMPTY,
    output logic [$clog2(DEPTH):0] COUNT,
    output logic                   OVF,
    input  logic                   REQ_COMMAND,
    output logic                   WR_DATA,
    output logic [47:0]            MEM_DDS_freq,
    output logic [47:0]            MEM_DDS_delta_freq,
    output logic [31:0]            MEM_DDS_delta_rate,
    output logic [63:0]            MEM_TIME_START,
    output logic [15:0]            MEM_N_impuls,
    output logic [1:0]             MEM_TYPE_impulse,
    output logic [31:0]            MEM_Interval_Ti,
    output logic [31:0]            MEM_Interval_Tp,
    output logic [31:0]            MEM_Tblank1,
    output logic [31:0]            MEM_Tblank2,
    output logic                   ARMED,
    output logic [15:0]            DONE_CNT,
    output logic [15:0]            LATE_CNT
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
    localparam logic [63:0]   MARGIN_T = 64'(MARGIN);

    typedef struct packed {
        logic [47:0] freq;
        logic [47:0] dfreq;
        logic [31:0] drate;
        logic [63:0] tstart;
        logic [15:0] n_imp;
        logic [1:0]  typ;
        logic [31:0] ti;
        logic [31:0] tp;
        logic [31:0] tb1;
        logic [31:0] tb2;
    } cmd_t;

    typedef enum logic [1:0] {StIdle, StCheck, StArmed, StRun} state_t;

    cmd_t          r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_d;
    logic          r_full;
    logic          r_empty;
    logic          r_ovf;
    logic          w_push;
    logic          w_pop;
    cmd_t          w_wr_entry;
    cmd_t          w_head;

    state_t        r_state;
    cmd_t          r_hold;
    cmd_t          r_out;
    logic          r_wr_data;
    logic          r_armed;
    logic [15:0]   r_done_cnt;
    logic [15:0]   r_late_cnt;
    logic          r_req_s;
    logic          r_req_q;
    logic          w_rise;
    logic          w_fall;
    logic          w_late;

    assign w_wr_entry = '{freq:   H_DDS_freq,
                          dfreq:  H_DDS_delta_freq,
                          drate:  H_DDS_delta_rate,
                          tstart: H_TIME_START,
                          n_imp:  H_N_impuls,
                          typ:    H_TYPE_impulse,
                          ti:     H_Interval_Ti,
                          tp:     H_Interval_Tp,
                          tb1:    H_Tblank1,
                          tb2:    H_Tblank2};

    assign w_head = r_mem[r_rd_ptr];
    assign w_push = HOST_WR && !r_full && !CLEAR;
    assign w_pop  = (r_state == StIdle) && !r_empty;

    // CLEAR still lets the FSM pop the current head; the flush wins for the pointers.
    always_comb begin
        w_count_d = r_count;
        if (CLEAR) begin
            w_count_d = '0;
        end else if (w_push && !w_pop) begin
            w_count_d = r_count + CW'(1);
        end else if (!w_push && w_pop) begin
            w_count_d = r_count - CW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_wr_entry;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET || CLEAR) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (HOST_WR && r_full) begin
                r_ovf <= 1'b1;
            end
        end
        if (RESET) begin
            r_count <= '0;
            r_empty <= 1'b1;
            r_full  <= 1'b0;
        end else begin
            r_count <= w_count_d;
            r_empty <= (w_count_d == '0);
            r_full  <= (w_count_d == FULL_LVL);
        end
    end

    // REQ_COMMAND is sampled once, then compared with its one-cycle delayed copy.
    assign w_rise = r_req_s && !r_req_q;
    assign w_fall = !r_req_s && r_req_q;
    assign w_late = (r_hold.tstart <= TIME + MARGIN_T);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state    <= StIdle;
            r_hold     <= '0;
            r_out      <= '0;
            r_wr_data  <= 1'b0;
            r_armed    <= 1'b0;
            r_done_cnt <= '0;
            r_late_cnt <= '0;
            r_req_s    <= 1'b0;
            r_req_q    <= 1'b0;
        end else begin
            r_req_s   <= REQ_COMMAND;
            r_req_q   <= r_req_s;
            r_wr_data <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (!r_empty) begin
                        r_hold  <= w_head;
                        r_state <= StCheck;
                    end
                end
                StCheck: begin
                    if (w_late) begin
                        r_late_cnt <= r_late_cnt + 16'd1;
                        r_state    <= StIdle;
                    end else begin
                        r_out     <= r_hold;
                        r_wr_data <= 1'b1;
                        r_armed   <= 1'b1;
                        r_state   <= StArmed;
                    end
                end
                StArmed: begin
                    if (w_rise) begin
                        r_state <= StRun;
                    end
                end
                StRun: begin
                    if (w_fall) begin
                        r_done_cnt <= r_done_cnt + 16'd1;
                        r_armed    <= 1'b0;
                        r_state    <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign FULL               = r_full;
    assign EMPTY              = r_empty;
    assign COUNT              = r_count;
    assign OVF                = r_ovf;
    assign WR_DATA            = r_wr_data;
    assign ARMED              = r_armed;
    assign DONE_CNT           = r_done_cnt;
    assign LATE_CNT           = r_late_cnt;
    assign MEM_DDS_freq       = r_out.freq;
    assign MEM_DDS_delta_freq = r_out.dfreq;
    assign MEM_DDS_delta_rate = r_out.drate;
    assign MEM_TIME_START     = r_out.tstart;
    assign MEM_N_impuls       = r_out.n_imp;
    assign MEM_TYPE_impulse   = r_out.typ;
    assign MEM_Interval_Ti    = r_out.ti;
    assign MEM_Interval_Tp    = r_out.tp;
    assign MEM_Tblank1        = r_out.tb1;
    assign MEM_Tblank2        = r_out.tb2;

endmodule

// File: tb/tb_cmd_registry.sv
// Directed bench for cmd_registry: load latency, completion pacing, late discard,
// overflow/clear, pointer wrap with simultaneous push/pop, and reset while running.
module tb_cmd_registry;

    localparam int unsigned DEPTH  = 16;
    localparam int unsigned MARGIN = 48;
    localparam logic [63:0] T0     = 64'd1_000_000;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [63:0] TIME = T0;
    logic        HOST_WR = 1'b0;
    logic [47:0] H_DDS_freq = '0;
    logic [47:0] H_DDS_delta_freq = '0;
    logic [31:0] H_DDS_delta_rate = '0;
    logic [63:0] H_TIME_START = '0;
    logic [15:0] H_N_impuls = '0;
    logic [1:0]  H_TYPE_impulse = '0;
    logic [31:0] H_Interval_Ti = '0;
    logic [31:0] H_Interval_Tp = '0;
    logic [31:0] H_Tblank1 = '0;
    logic [31:0] H_Tblank2 = '0;
    logic        CLEAR = 1'b0;
    logic        REQ_COMMAND = 1'b0;
    logic        FULL, EMPTY, OVF, WR_DATA, ARMED;
    logic [4:0]  COUNT;
    logic [47:0] MEM_DDS_freq, MEM_DDS_delta_freq;
    logic [31:0] MEM_DDS_delta_rate;
    logic [63:0] MEM_TIME_START;
    logic [15:0] MEM_N_impuls;
    logic [1:0]  MEM_TYPE_impulse;
    logic [31:0] MEM_Interval_Ti, MEM_Interval_Tp, MEM_Tblank1, MEM_Tblank2;
    logic [15:0] DONE_CNT, LATE_CNT;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 CLK = ~CLK;

    cmd_registry #(.DEPTH(DEPTH), .MARGIN(MARGIN)) dut (
        .CLK(CLK), .RESET(RESET), .TIME(TIME), .HOST_WR(HOST_WR),
        .H_DDS_freq(H_DDS_freq), .H_DDS_delta_freq(H_DDS_delta_freq),
        .H_DDS_delta_rate(H_DDS_delta_rate), .H_TIME_START(H_TIME_START),
        .H_N_impuls(H_N_impuls), .H_TYPE_impulse(H_TYPE_impulse),
        .H_Interval_Ti(H_Interval_Ti), .H_Interval_Tp(H_Interval_Tp),
        .H_Tblank1(H_Tblank1), .H_Tblank2(H_Tblank2), .CLEAR(CLEAR),
        .FULL(FULL), .EMPTY(EMPTY), .COUNT(COUNT), .OVF(OVF),
        .REQ_COMMAND(REQ_COMMAND), .WR_DATA(WR_DATA),
        .MEM_DDS_freq(MEM_DDS_freq), .MEM_DDS_delta_freq(MEM_DDS_delta_freq),
        .MEM_DDS_delta_rate(MEM_DDS_delta_rate), .MEM_TIME_START(MEM_TIME_START),
        .MEM_N_impuls(MEM_N_impuls), .MEM_TYPE_impulse(MEM_TYPE_impulse),
        .MEM_Interval_Ti(MEM_Interval_Ti), .MEM_Interval_Tp(MEM_Interval_Tp),
        .MEM_Tblank1(MEM_Tblank1), .MEM_Tblank2(MEM_Tblank2),
        .ARMED(ARMED), .DONE_CNT(DONE_CNT), .LATE_CNT(LATE_CNT)
    );

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    // Field values are derived from the id so every field is distinguishable per entry.
    task automatic push_cmd(input logic [63:0] ts, input logic [15:0] id, input logic clr);
        HOST_WR          = 1'b1;
        CLEAR            = clr;
        H_TIME_START     = ts;
        H_N_impuls       = id;
        H_DDS_freq       = {32'hABCD_0000, id};
        H_DDS_delta_freq = {32'h1234_0000, ~id};
        H_DDS_delta_rate = {16'h55AA, id};
        H_TYPE_impulse   = id[1:0];
        H_Interval_Ti    = {id, 16'h0001};
        H_Interval_Tp    = {id, 16'h0002};
        H_Tblank1        = {id, 16'h0003};
        H_Tblank2        = {id, 16'h0004};
        tick();
        HOST_WR = 1'b0;
        CLEAR   = 1'b0;
    endtask

    // Returns two cycles after REQ_COMMAND falls, i.e. when the FSM is back in idle.
    task automatic complete_cmd(input int hi);
        REQ_COMMAND = 1'b1;
        repeat (hi) tick();
        REQ_COMMAND = 1'b0;
        tick();
        tick();
    endtask

    task automatic wait_wr(output bit ok);
        int i;
        ok = 1'b0;
        i  = 0;
        while (!ok && i < 20) begin
            if (WR_DATA === 1'b1) ok = 1'b1;
            else begin
                tick();
                i++;
            end
        end
    endtask

    task automatic test_reset;
        RESET = 1'b1;
        tick();
        tick();
        RESET = 1'b0;
        tick();
        n_checks++; if (WR_DATA !== 1'b0) $display("FAIL rst_wr_data: got %0h want 0", WR_DATA); else n_pass++;
        n_checks++; if (ARMED !== 1'b0) $display("FAIL rst_armed: got %0h want 0", ARMED); else n_pass++;
        n_checks++; if (COUNT !== 5'd0) $display("FAIL rst_count: got %0d want 0", COUNT); else n_pass++;
        n_checks++; if (EMPTY !== 1'b1) $display("FAIL rst_empty: got %0h want 1", EMPTY); else n_pass++;
        n_checks++; if (FULL !== 1'b0) $display("FAIL rst_full: got %0h want 0", FULL); else n_pass++;
        n_checks++; if (OVF !== 1'b0) $display("FAIL rst_ovf: got %0h want 0", OVF); else n_pass++;
        n_checks++; if (DONE_CNT !== 16'd0) $display("FAIL rst_done: got %0d want 0", DONE_CNT); else n_pass++;
        n_checks++; if (LATE_CNT !== 16'd0) $display("FAIL rst_late: got %0d want 0", LATE_CNT); else n_pass++;
        n_checks++; if (MEM_TIME_START !== 64'd0) $display("FAIL rst_mem_ts: got %0h want 0", MEM_TIME_START); else n_pass++;
        n_checks++; if (MEM_N_impuls !== 16'd0) $display("FAIL rst_mem_n: got %0h want 0", MEM_N_impuls); else n_pass++;
    endtask

    task automatic test_load;
        push_cmd(T0 + 64'd1000, 16'd3, 1'b0);
        n_checks++; if (EMPTY !== 1'b0) $display("FAIL load_empty_n1: got %0h want 0", EMPTY); else n_pass++;
        n_checks++; if (WR_DATA !== 1'b0) $display("FAIL load_wr_n1: got %0h want 0", WR_DATA); else n_pass++;
        tick();
        n_checks++; if (WR_DATA !== 1'b0) $display("FAIL load_wr_n2: got %0h want 0", WR_DATA); else n_pass++;
        tick();
        n_checks++; if (WR_DATA !== 1'b1) $display("FAIL load_wr_n3: got %0h want 1", WR_DATA); else n_pass++;
        n_checks++; if (ARMED !== 1'b1) $display("FAIL load_armed: got %0h want 1", ARMED); else n_pass++;
        n_checks++; if (MEM_TIME_START !== T0 + 64'd1000) $display("FAIL load_ts: got %0h want %0h", MEM_TIME_START, T0 + 64'd1000); else n_pass++;
        n_checks++; if (MEM_N_impuls !== 16'd3) $display("FAIL load_n: got %0h want 3", MEM_N_impuls); else n_pass++;
        n_checks++; if (MEM_DDS_freq !== 48'hABCD_0000_0003) $display("FAIL load_freq: got %0h want abcd00000003", MEM_DDS_freq); else n_pass++;
        n_checks++; if (MEM_DDS_delta_freq !== 48'h1234_0000_FFFC) $display("FAIL load_dfreq: got %0h want 12340000fffc", MEM_DDS_delta_freq); else n_pass++;
        n_checks++; if (MEM_DDS_delta_rate !== 32'h55AA_0003) $display("FAIL load_rate: got %0h want 55aa0003", MEM_DDS_delta_rate); else n_pass++;
        n_checks++; if (MEM_TYPE_impulse !== 2'd3) $display("FAIL load_type: got %0h want 3", MEM_TYPE_impulse); else n_pass++;
        n_checks++; if (MEM_Interval_Ti !== 32'h0003_0001) $display("FAIL load_ti: got %0h want 30001", MEM_Interval_Ti); else n_pass++;
        n_checks++; if (MEM_Interval_Tp !== 32'h0003_0002) $display("FAIL load_tp: got %0h want 30002", MEM_Interval_Tp); else n_pass++;
        n_checks++; if (MEM_Tblank1 !== 32'h0003_0003) $display("FAIL load_tb1: got %0h want 30003", MEM_Tblank1); else n_pass++;
        n_checks++; if (MEM_Tblank2 !== 32'h0003_0004) $display("FAIL load_tb2: got %0h want 30004", MEM_Tblank2); else n_pass++;
        tick();
        n_checks++; if (WR_DATA !== 1'b0) $display("FAIL load_wr_n4: got %0h want 0", WR_DATA); else n_pass++;
        n_checks++; if (ARMED !== 1'b1) $display("FAIL load_armed_n4: got %0h want 1", ARMED); else n_pass++;
    endtask

    task automatic test_run;
        bit stable;
        push_cmd(T0 + 64'd2000, 16'd10, 1'b0);
        push_cmd(T0 + 64'd2000, 16'd11, 1'b0);
        n_checks++; if (COUNT !== 5'd2) $display("FAIL run_count: got %0d want 2", COUNT); else n_pass++;
        REQ_COMMAND = 1'b1;
        stable = 1'b1;
        repeat (50) begin
            tick();
            if (MEM_N_impuls !== 16'd3 || WR_DATA !== 1'b0) stable = 1'b0;
        end
        n_checks++; if (stable !== 1'b1) $display("FAIL run_mem_stable: got %0h want 1", stable); else n_pass++;
        n_checks++; if (ARMED !== 1'b1) $display("FAIL run_armed: got %0h want 1", ARMED); else n_pass++;
        REQ_COMMAND = 1'b0;
        tick();
        n_checks++; if (DONE_CNT !== 16'd0) $display("FAIL run_done_m1: got %0d want 0", DONE_CNT); else n_pass++;
        tick();
        n_checks++; if (DONE_CNT !== 16'd1) $display("FAIL run_done_m2: got %0d want 1", DONE_CNT); else n_pass++;
        n_checks++; if (ARMED !== 1'b0) $display("FAIL run_armed_m2: got %0h want 0", ARMED); else n_pass++;
        tick();
        n_checks++; if (WR_DATA !== 1'b0) $display("FAIL run_wr_m3: got %0h want 0", WR_DATA); else n_pass++;
        tick();
        n_checks++; if (WR_DATA !== 1'b1) $display("FAIL run_wr_m4: got %0h want 1", WR_DATA); else n_pass++;
        n_checks++; if (MEM_N_impuls !== 16'd10) $display("FAIL run_n_m4: got %0d want 10", MEM_N_impuls); else n_pass++;
        n_checks++; if (COUNT !== 5'd1) $display("FAIL run_count_m4: got %0d want 1", COUNT); else n_pass++;
        complete_cmd(4);
        n_checks++; if (DONE_CNT !== 16'd2) $display("FAIL run_done2: got %0d want 2", DONE_CNT); else n_pass++;
        tick();
        tick();
        n_checks++; if (WR_DATA !== 1'b1 || MEM_N_impuls !== 16'd11) $display("FAIL run_second: got wr=%0h n=%0d want wr=1 n=11", WR_DATA, MEM_N_impuls); else n_pass++;
        complete_cmd(4);
        repeat (4) tick();
        n_checks++; if (DONE_CNT !== 16'd3) $display("FAIL run_done3: got %0d want 3", DONE_CNT); else n_pass++;
        n_checks++; if (EMPTY !== 1'b1 || ARMED !== 1'b0) $display("FAIL run_drained: got empty=%0h armed=%0h want 1/0", EMPTY, ARMED); else n_pass++;
    endtask

    task automatic test_late;
        bit seen;
        push_cmd(T0 + 64'd10, 16'd20, 1'b0);
        seen = 1'b0;
        repeat (6) begin
            tick();
            if (WR_DATA === 1'b1) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b0) $display("FAIL late_no_wr: got %0h want 0", seen); else n_pass++;
        n_checks++; if (LATE_CNT !== 16'd1) $display("FAIL late_cnt1: got %0d want 1", LATE_CNT); else n_pass++;
        n_checks++; if (EMPTY !== 1'b1 || ARMED !== 1'b0) $display("FAIL late_state: got empty=%0h armed=%0h want 1/0", EMPTY, ARMED); else n_pass++;
        push_cmd(T0 + 64'd48, 16'd21, 1'b0);
        repeat (4) tick();
        n_checks++; if (LATE_CNT !== 16'd2) $display("FAIL late_equal_margin: got %0d want 2", LATE_CNT); else n_pass++;
        push_cmd(T0 + 64'd49, 16'd22, 1'b0);
        tick();
        tick();
        n_checks++; if (WR_DATA !== 1'b1) $display("FAIL late_margin_plus1_wr: got %0h want 1", WR_DATA); else n_pass++;
        n_checks++; if (MEM_TIME_START !== T0 + 64'd49) $display("FAIL late_margin_plus1_ts: got %0h want %0h", MEM_TIME_START, T0 + 64'd49); else n_pass++;
        n_checks++; if (LATE_CNT !== 16'd2) $display("FAIL late_cnt_hold: got %0d want 2", LATE_CNT); else n_pass++;
        push_cmd(T0 + 64'd5, 16'd30, 1'b0);
        push_cmd(T0 + 64'd6, 16'd31, 1'b0);
        push_cmd(T0 + 64'd5000, 16'd32, 1'b0);
        complete_cmd(4);
        n_checks++; if (DONE_CNT !== 16'd4) $display("FAIL late_done4: got %0d want 4", DONE_CNT); else n_pass++;
        repeat (5) tick();
        n_checks++; if (WR_DATA !== 1'b0) $display("FAIL late_b2b_m7: got %0h want 0", WR_DATA); else n_pass++;
        tick();
        n_checks++; if (WR_DATA !== 1'b1 || MEM_N_impuls !== 16'd32) $display("FAIL late_b2b_m8: got wr=%0h n=%0d want wr=1 n=32", WR_DATA, MEM_N_impuls); else n_pass++;
        n_checks++; if (LATE_CNT !== 16'd4) $display("FAIL late_cnt4: got %0d want 4", LATE_CNT); else n_pass++;
    endtask

    task automatic test_full;
        for (int i = 0; i < 16; i++) push_cmd(T0 + 64'd3000, 16'(100 + i), 1'b0);
        n_checks++; if (COUNT !== 5'd16) $display("FAIL full_count: got %0d want 16", COUNT); else n_pass++;
        n_checks++; if (FULL !== 1'b1 || EMPTY !== 1'b0) $display("FAIL full_flags: got full=%0h empty=%0h want 1/0", FULL, EMPTY); else n_pass++;
        n_checks++; if (OVF !== 1'b0) $display("FAIL full_ovf_pre: got %0h want 0", OVF); else n_pass++;
        push_cmd(T0 + 64'd3000, 16'd116, 1'b0);
        n_checks++; if (OVF !== 1'b1) $display("FAIL full_ovf: got %0h want 1", OVF); else n_pass++;
        n_checks++; if (COUNT !== 5'd16) $display("FAIL full_count17: got %0d want 16", COUNT); else n_pass++;
        CLEAR = 1'b1;
        tick();
        CLEAR = 1'b0;
        n_checks++; if (COUNT !== 5'd0) $display("FAIL clr_count: got %0d want 0", COUNT); else n_pass++;
        n_checks++; if (OVF !== 1'b0) $display("FAIL clr_ovf: got %0h want 0", OVF); else n_pass++;
        n_checks++; if (FULL !== 1'b0 || EMPTY !== 1'b1) $display("FAIL clr_flags: got full=%0h empty=%0h want 0/1", FULL, EMPTY); else n_pass++;
        n_checks++; if (ARMED !== 1'b1 || MEM_N_impuls !== 16'd32) $display("FAIL clr_keep: got armed=%0h n=%0d want 1/32", ARMED, MEM_N_impuls); else n_pass++;
        push_cmd(T0 + 64'd3000, 16'd117, 1'b1);
        n_checks++; if (COUNT !== 5'd0 || OVF !== 1'b0) $display("FAIL clr_beats_wr: got count=%0d ovf=%0h want 0/0", COUNT, OVF); else n_pass++;
    endtask

    task automatic test_back_to_back;
        bit ok;
        for (int i = 0; i < 5; i++) push_cmd(T0 + 64'd4000, 16'(200 + i), 1'b0);
        n_checks++; if (COUNT !== 5'd5) $display("FAIL b2b_count5: got %0d want 5", COUNT); else n_pass++;
        complete_cmd(4);
        n_checks++; if (DONE_CNT !== 16'd5) $display("FAIL b2b_done5: got %0d want 5", DONE_CNT); else n_pass++;
        push_cmd(T0 + 64'd4000, 16'd205, 1'b0);
        n_checks++; if (COUNT !== 5'd5) $display("FAIL b2b_push_pop: got %0d want 5", COUNT); else n_pass++;
        tick();
        n_checks++; if (WR_DATA !== 1'b1 || MEM_N_impuls !== 16'd200) $display("FAIL b2b_first: got wr=%0h n=%0d want wr=1 n=200", WR_DATA, MEM_N_impuls); else n_pass++;
        for (int k = 1; k < 30; k++) begin
            if (k <= 24) push_cmd(T0 + 64'd4000, 16'(205 + k), 1'b0);
            complete_cmd(4);
            wait_wr(ok);
            n_checks++;
            if (!ok || MEM_N_impuls !== 16'(200 + k))
                $display("FAIL b2b_order_%0d: got wr_seen=%0h n=%0d want 1/%0d", k, ok, MEM_N_impuls, 200 + k);
            else n_pass++;
        end
        n_checks++; if (DONE_CNT !== 16'd34) $display("FAIL b2b_done34: got %0d want 34", DONE_CNT); else n_pass++;
        n_checks++; if (COUNT !== 5'd0 || ARMED !== 1'b1) $display("FAIL b2b_end: got count=%0d armed=%0h want 0/1", COUNT, ARMED); else n_pass++;
    endtask

    task automatic test_reset_run;
        bit seen;
        REQ_COMMAND = 1'b1;
        repeat (4) tick();
        RESET = 1'b1;
        tick();
        n_checks++; if (WR_DATA !== 1'b0 || ARMED !== 1'b0) $display("FAIL rr_ctrl: got wr=%0h armed=%0h want 0/0", WR_DATA, ARMED); else n_pass++;
        n_checks++; if (DONE_CNT !== 16'd0 || LATE_CNT !== 16'd0) $display("FAIL rr_cnts: got done=%0d late=%0d want 0/0", DONE_CNT, LATE_CNT); else n_pass++;
        n_checks++; if (COUNT !== 5'd0 || EMPTY !== 1'b1) $display("FAIL rr_fifo: got count=%0d empty=%0h want 0/1", COUNT, EMPTY); else n_pass++;
        n_checks++; if (MEM_N_impuls !== 16'd0 || MEM_TIME_START !== 64'd0) $display("FAIL rr_mem: got n=%0h ts=%0h want 0/0", MEM_N_impuls, MEM_TIME_START); else n_pass++;
        RESET = 1'b0;
        repeat (3) tick();
        REQ_COMMAND = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            tick();
            if (WR_DATA === 1'b1) seen = 1'b1;
        end
        n_checks++; if (DONE_CNT !== 16'd0) $display("FAIL rr_done_after_fall: got %0d want 0", DONE_CNT); else n_pass++;
        n_checks++; if (seen !== 1'b0) $display("FAIL rr_no_wr: got %0h want 0", seen); else n_pass++;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_load();
        test_run();
        test_late();
        test_full();
        test_back_to_back();
        test_reset_run();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
